// File: rtl/sequencer_pkg.sv
// Shared types and phase encodings for the instruction phase sequencer.
package sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  localparam logic [2:0] PHASE_NONE  = 3'b000;
  localparam logic [2:0] PHASE_FETCH = 3'b001;
  localparam logic [2:0] PHASE_EXEC  = 3'b010;
  localparam logic [2:0] PHASE_WB    = 3'b100;

  // Anything that is not FETCH or EXEC restarts the ring at FETCH.
  function automatic logic [2:0] advance_phase(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      PHASE_FETCH: nxt = PHASE_EXEC;
      PHASE_EXEC:  nxt = PHASE_WB;
      default:     nxt = PHASE_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Request/status bundle between phase_sequencer (slave) and the core top level (master).
// With SINGLE_STEP_EN defined the bundle also carries the step request.
interface phase_sequencer_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     mem_access;
  logic                     mem_ready;
  logic                     halt_request;
  logic                     clear_timeout;
`ifdef SINGLE_STEP_EN
  logic                     step;
`endif
  logic [3:1]               phase;
  logic                     stalled;
  logic                     halted;
  logic                     bus_timeout;
  logic [COUNTER_WIDTH-1:0] instret;

  modport master (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output mem_access,
    output mem_ready,
    output halt_request,
    output clear_timeout,
    input  phase,
    input  stalled,
    input  halted,
    input  bus_timeout,
    input  instret
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  mem_access,
    input  mem_ready,
    input  halt_request,
    input  clear_timeout,
    output phase,
    output stalled,
    output halted,
    output bus_timeout,
    output instret
  );
endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// Per-phase stall counter; timeout fires on the stall edge that would bring the count to MAX_WAIT.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_r;

  assign timeout = inc & (cnt_r == CNT_LAST);

  // Stall count register; clear has priority over increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase strobe generator with memory stall stretching, bus timeout, debug halt and instret.
// Optional macro SINGLE_STEP_EN adds a step request that runs one instruction out of HALT.
module phase_sequencer
  import sequencer_pkg::*;
#(
  parameter int MAX_WAIT      = 15,
  parameter int RESET_CYCLES  = 2,
  parameter int COUNTER_WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  phase_sequencer_if.slave bus
);
  localparam int               HOLD_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  seq_state_t               state_r, state_nxt_s;
  logic [3:1]               phase_r, phase_nxt_s;
  logic                     stalled_r, stalled_nxt_s;
  logic                     halted_r, bus_timeout_r;
  logic [COUNTER_WIDTH-1:0] instret_r, instret_nxt_s;
  logic [HOLD_W-1:0]        hold_cnt_r, hold_cnt_nxt_s;
  logic                     step_active_r, step_active_nxt_s;
  logic                     step_req_s;
  logic                     stall_s;
  logic                     timeout_s;

`ifdef SINGLE_STEP_EN
  assign step_req_s = bus.step;
`else
  assign step_req_s = 1'b0;
`endif

  // mem_ready only matters while the current phase owns the pad.
  assign stall_s = (state_r == RUN) & bus.mem_access & ~bus.mem_ready;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (~stall_s),
    .inc     (stall_s),
    .timeout (timeout_s)
  );

  // Next-state, next-phase and retire-count decisions.
  always_comb begin
    state_nxt_s       = state_r;
    phase_nxt_s       = phase_r;
    stalled_nxt_s     = 1'b0;
    instret_nxt_s     = instret_r;
    hold_cnt_nxt_s    = hold_cnt_r;
    step_active_nxt_s = step_active_r;
    case (state_r)
      HOLD: begin
        phase_nxt_s = PHASE_NONE;
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s    = RUN;
          phase_nxt_s    = PHASE_FETCH;
          hold_cnt_nxt_s = '0;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1'b1);
        end
      end
      RUN: begin
        if (timeout_s) begin
          // The faulted instruction is abandoned and never counted.
          state_nxt_s       = FAULT;
          phase_nxt_s       = PHASE_NONE;
          step_active_nxt_s = 1'b0;
        end else if (stall_s) begin
          stalled_nxt_s = 1'b1;
        end else if (phase_r == PHASE_WB) begin
          instret_nxt_s = instret_r + COUNTER_WIDTH'(1'b1);
          if (step_active_r || bus.halt_request) begin
            state_nxt_s       = HALT;
            phase_nxt_s       = PHASE_NONE;
            step_active_nxt_s = 1'b0;
          end else begin
            phase_nxt_s = PHASE_FETCH;
          end
        end else begin
          phase_nxt_s = advance_phase(phase_r);
        end
      end
      HALT: begin
        phase_nxt_s = PHASE_NONE;
        if (step_req_s) begin
          state_nxt_s       = RUN;
          phase_nxt_s       = PHASE_FETCH;
          step_active_nxt_s = 1'b1;
        end else if (!bus.halt_request) begin
          state_nxt_s = RUN;
          phase_nxt_s = PHASE_FETCH;
        end else begin
          state_nxt_s = HALT;
        end
      end
      FAULT: begin
        if (bus.clear_timeout) begin
          state_nxt_s = RUN;
          phase_nxt_s = PHASE_FETCH;
        end else begin
          phase_nxt_s = PHASE_NONE;
        end
      end
      default: begin
        state_nxt_s       = HOLD;
        phase_nxt_s       = PHASE_NONE;
        hold_cnt_nxt_s    = '0;
        step_active_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state so they stay registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= HOLD;
      phase_r       <= PHASE_NONE;
      stalled_r     <= 1'b0;
      halted_r      <= 1'b0;
      bus_timeout_r <= 1'b0;
      instret_r     <= '0;
      hold_cnt_r    <= '0;
      step_active_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      phase_r       <= phase_nxt_s;
      stalled_r     <= stalled_nxt_s;
      halted_r      <= (state_nxt_s == HALT);
      bus_timeout_r <= (state_nxt_s == FAULT);
      instret_r     <= instret_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      step_active_r <= step_active_nxt_s;
    end
  end

  assign bus.phase       = phase_r;
  assign bus.stalled     = stalled_r;
  assign bus.halted      = halted_r;
  assign bus.bus_timeout = bus_timeout_r;
  assign bus.instret     = instret_r;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: abstract cycle model compared every cycle plus literal checkpoints.
module tb_phase_sequencer;
  localparam int MAX_WAIT     = 15;
  localparam int RESET_CYCLES = 2;
  localparam int CW           = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  phase_sequencer_if #(.COUNTER_WIDTH(CW)) bus_if ();

  phase_sequencer #(
    .MAX_WAIT      (MAX_WAIT),
    .RESET_CYCLES  (RESET_CYCLES),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  logic step_in;
`ifdef SINGLE_STEP_EN
  assign step_in = bus_if.step;
`else
  assign step_in = 1'b0;
`endif

  // Model: mode 0=waiting after reset, 1=running, 2=halted, 3=faulted; pos = index of active phase bit.
  int          m_mode, m_hold, m_pos, m_wait;
  logic        m_step, m_stl;
  logic [CW-1:0] m_cnt;

  always @(posedge clock or negedge reset) begin : model
    int mode, hold, pos, wt;
    logic stp, stl;
    logic [CW-1:0] cnt;
    if (!reset) begin
      m_mode <= 0; m_hold <= RESET_CYCLES; m_pos <= 0; m_wait <= 0;
      m_step <= 1'b0; m_stl <= 1'b0; m_cnt <= '0;
    end else begin
      mode = m_mode; hold = m_hold; pos = m_pos; wt = m_wait;
      stp = m_step; stl = 1'b0; cnt = m_cnt;
      case (mode)
        0: begin
          hold = hold - 1;
          if (hold == 0) begin mode = 1; pos = 0; end
        end
        1: begin
          if (bus_if.mem_access && !bus_if.mem_ready) begin
            wt = wt + 1;
            if (wt >= MAX_WAIT) begin mode = 3; wt = 0; stp = 1'b0; end
            else stl = 1'b1;
          end else begin
            wt = 0;
            if (pos == 2) begin
              cnt = cnt + 1;
              pos = 0;
              if (stp || bus_if.halt_request) begin mode = 2; stp = 1'b0; end
            end else begin
              pos = pos + 1;
            end
          end
        end
        2: begin
          if (step_in) begin mode = 1; pos = 0; stp = 1'b1; end
          else if (!bus_if.halt_request) begin mode = 1; pos = 0; end
        end
        3: begin
          if (bus_if.clear_timeout) begin mode = 1; pos = 0; end
        end
        default: mode = 0;
      endcase
      m_mode <= mode; m_hold <= hold; m_pos <= pos; m_wait <= wt;
      m_step <= stp; m_stl <= stl; m_cnt <= cnt;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clock) begin : compare
    logic [2:0] ep;
    ep = (m_mode == 1) ? (3'b001 << m_pos[1:0]) : 3'b000;
    n_tests++;
    if ({bus_if.phase, bus_if.stalled, bus_if.halted, bus_if.bus_timeout, bus_if.instret} !==
        {ep, m_stl, (m_mode == 2), (m_mode == 3), m_cnt}) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got ph=%b st=%b h=%b to=%b ir=%0d, expected ph=%b st=%b h=%b to=%b ir=%0d",
               $time, bus_if.phase, bus_if.stalled, bus_if.halted, bus_if.bus_timeout, bus_if.instret,
               ep, m_stl, (m_mode == 2), (m_mode == 3), m_cnt);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    bus_if.mem_access    = 1'b0;
    bus_if.mem_ready     = 1'b1;
    bus_if.halt_request  = 1'b0;
    bus_if.clear_timeout = 1'b0;
`ifdef SINGLE_STEP_EN
    bus_if.step          = 1'b0;
`endif
    #1 reset = 1'b0;
    tick(); tick();
    check("reset_phase", bus_if.phase, 0);
    check("reset_instret", bus_if.instret, 0);
    check("reset_flags", {bus_if.stalled, bus_if.halted, bus_if.bus_timeout}, 0);

    // Reset release: two idle cycles then the phase ring; stray clear_timeout ignored.
    reset = 1'b1;
    tick(); check("hold_phase", bus_if.phase, 0);
    tick(); check("first_fetch", bus_if.phase, 1);
    bus_if.clear_timeout = 1'b1;
    tick(); check("first_exec", bus_if.phase, 2);
    bus_if.clear_timeout = 1'b0;
    tick(); check("first_wb", bus_if.phase, 4);
    check("first_wb_instret", bus_if.instret, 0);
    repeat (7) tick();
    check("instret_after_9", bus_if.instret, 3);
    check("fetch_after_9", bus_if.phase, 1);

    // Four stall cycles in EXEC.
    tick(); check("exec_before_stall", bus_if.phase, 2);
    bus_if.mem_access = 1'b1; bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_exec_phase", bus_if.phase, 2);
      check("stall_exec_flag", bus_if.stalled, 1);
    end
    bus_if.mem_ready = 1'b1;
    tick(); check("after_stall_wb", bus_if.phase, 4);
    check("after_stall_flag", bus_if.stalled, 0);
    bus_if.mem_access = 1'b0;
    tick(); check("seven_clock_instr", bus_if.phase, 1);
    check("seven_clock_instret", bus_if.instret, 4);

    // Bus timeout after 15 unacknowledged cycles in FETCH.
    bus_if.mem_access = 1'b1; bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("pre_timeout_phase", bus_if.phase, 1);
    end
    tick();
    check("timeout_flag", bus_if.bus_timeout, 1);
    check("timeout_phase", bus_if.phase, 0);
    check("timeout_instret", bus_if.instret, 4);
    bus_if.mem_access = 1'b0; bus_if.mem_ready = 1'b1;
    tick(); check("timeout_sticky", bus_if.bus_timeout, 1);
    bus_if.clear_timeout = 1'b1;
    tick(); check("cleared_phase", bus_if.phase, 1);
    check("cleared_flag", bus_if.bus_timeout, 0);
    bus_if.clear_timeout = 1'b0;

    // Halt requested during EXEC takes effect at the instruction boundary.
    tick();
    bus_if.halt_request = 1'b1;
    tick(); check("halt_pending", bus_if.halted, 0);
    tick(); check("halted", bus_if.halted, 1);
    check("halted_phase", bus_if.phase, 0);
    check("halted_instret", bus_if.instret, 5);
    tick(); check("halt_holds", bus_if.halted, 1);
    bus_if.halt_request = 1'b0;
    tick(); check("resume_phase", bus_if.phase, 1);
    check("resume_flag", bus_if.halted, 0);

    // A halt pulse away from the WB edge is ignored.
    bus_if.halt_request = 1'b1;
    tick();
    bus_if.halt_request = 1'b0;
    tick(); tick();
    check("pulse_ignored", bus_if.halted, 0);
    check("pulse_instret", bus_if.instret, 6);

    // Stall in WB defers the halt.
    tick();
    bus_if.halt_request = 1'b1;
    tick();
    bus_if.mem_access = 1'b1; bus_if.mem_ready = 1'b0;
    tick(); check("wb_stall_phase", bus_if.phase, 4);
    check("wb_stall_not_halted", bus_if.halted, 0);
    tick();
    bus_if.mem_ready = 1'b1;
    tick(); check("wb_stall_halted", bus_if.halted, 1);
    check("wb_stall_instret", bus_if.instret, 7);
    bus_if.mem_access = 1'b0; bus_if.halt_request = 1'b0;
    tick(); check("wb_stall_resume", bus_if.phase, 1);

`ifdef SINGLE_STEP_EN
    // Single step out of HALT while halt_request stays high.
    bus_if.halt_request = 1'b1;
    tick(); tick(); tick();
    check("step_pre_halt", bus_if.halted, 1);
    bus_if.step = 1'b1;
    tick(); check("step_fetch", bus_if.phase, 1);
    bus_if.step = 1'b0;
    tick(); check("step_exec", bus_if.phase, 2);
    tick(); check("step_wb", bus_if.phase, 4);
    tick(); check("step_rehalt", bus_if.halted, 1);
    check("step_instret", bus_if.instret, 9);
    tick();
    bus_if.halt_request = 1'b0;
    tick(); check("step_resume", bus_if.phase, 1);
`endif

    // Asynchronous reset during a stalled WB.
    tick(); tick();
    bus_if.mem_access = 1'b1; bus_if.mem_ready = 1'b0;
    tick(); check("pre_reset_stall", bus_if.stalled, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_phase", bus_if.phase, 0);
    check("async_reset_instret", bus_if.instret, 0);
    check("async_reset_stalled", bus_if.stalled, 0);
    tick();
    reset = 1'b1;
    bus_if.mem_access = 1'b0; bus_if.mem_ready = 1'b1;
    tick(); check("rerun_hold", bus_if.phase, 0);
    tick(); check("rerun_fetch", bus_if.phase, 1);

    // Mixed deterministic patterns checked only by the model.
    for (int i = 0; i < 150; i++) begin
      bus_if.mem_access    = ((i % 5) < 2);
      bus_if.mem_ready     = ((i % 7) != 0);
      bus_if.halt_request  = ((i % 23) > 18);
      bus_if.clear_timeout = ((i % 11) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
